apb_master_arbiter: RTL and testbench



---
 rtl/apb_master_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
//   Shares one APB master port among N_REQ on-chip requesters. Arbitration is
//   round-robin. The block generates the APB SETUP/ACCESS phases itself and
//   ends a transfer with an error if the slave never raises PREADY.
//
// Ports
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_req*            per-requester request level, direction, packed addr/wdata
//   o_req_ack         one-cycle one-hot completion pulse
//   o_req_rdata/err   completion data/error, meaningful while o_req_ack != 0
//   o_grant, o_busy   current owner (one-hot) and transfer-in-progress flag
//   o_p*, i_p*        APB master signals towards the PD0 bus
module apb_master_arbiter #(
    parameter int N_REQ          = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_REQ-1:0]            i_req,
    input  logic [N_REQ-1:0]            i_req_write,
    input  logic [N_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] i_req_wdata,
    output logic [N_REQ-1:0]            o_req_ack,
    output logic [DATA_WIDTH-1:0]       o_req_rdata,
    output logic                        o_req_err,
    output logic [N_REQ-1:0]            o_grant,
    output logic                        o_busy,
    output logic [ADDR_WIDTH-1:0]       o_paddr,
    output logic                        o_pwrite,
    output logic                        o_psel,
    output logic                        o_penable,
    output logic [DATA_WIDTH-1:0]       o_pwdata,
    input  logic [DATA_WIDTH-1:0]       i_prdata,
    input  logic                        i_pready,
    input  logic                        i_pslverr
);

    localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [LW-1:0] LAST_RST = LW'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t                  state_q, state_d;
    logic [LW-1:0]           last_q, last_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    logic [N_REQ-1:0]        ack_d;
    logic [DATA_WIDTH-1:0]   rdata_d;
    logic                    err_d;
    logic [N_REQ-1:0]        grant_d;
    logic                    busy_d;
    logic [ADDR_WIDTH-1:0]   paddr_d;
    logic                    pwrite_d;
    logic                    psel_d;
    logic                    penable_d;
    logic [DATA_WIDTH-1:0]   pwdata_d;

    logic [N_REQ-1:0]        eligible;
    logic [N_REQ-1:0]        eligible_sh;
    logic [N_REQ-1:0]        write_sh;
    logic                    found;
    int unsigned             win;
    int unsigned             cand;
    logic                    done;

    // Round-robin search starting just after the last owner. A requester
    // whose ack is on the outputs this cycle is masked, so a requester that
    // has not yet dropped i_req is not re-granted straight away.
    always_comb begin
        eligible    = i_req & ~o_req_ack;
        eligible_sh = '0;
        found       = 1'b0;
        win         = 0;
        cand        = 0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand        = (32'(last_q) + off) % N_REQ;
            eligible_sh = eligible >> cand;
            if (!found && eligible_sh[0]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        ack_d     = '0;
        rdata_d   = o_req_rdata;
        err_d     = o_req_err;
        grant_d   = o_grant;
        busy_d    = o_busy;
        paddr_d   = o_paddr;
        pwrite_d  = o_pwrite;
        psel_d    = o_psel;
        penable_d = o_penable;
        pwdata_d  = o_pwdata;
        write_sh  = i_req_write >> win;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (found) begin
                    paddr_d   = ADDR_WIDTH'(i_req_addr >> (win * ADDR_WIDTH));
                    pwdata_d  = DATA_WIDTH'(i_req_wdata >> (win * DATA_WIDTH));
                    pwrite_d  = write_sh[0];
                    grant_d   = N_REQ'(1) << win;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    busy_d    = 1'b1;
                    last_d    = LW'(win);
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // PREADY is tested first so it wins over a timeout on the same edge.
                if (i_pready) begin
                    done    = 1'b1;
                    rdata_d = o_pwrite ? '0 : i_prdata;
                    err_d   = i_pslverr;
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (cnt_q == CNT_LAST) begin
                        done    = 1'b1;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                if (done) begin
                    ack_d     = o_grant;
                    grant_d   = '0;
                    psel_d    = 1'b0;
                    penable_d = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            last_q      <= LAST_RST;
            cnt_q       <= '0;
            o_req_ack   <= '0;
            o_req_rdata <= '0;
            o_req_err   <= 1'b0;
            o_grant     <= '0;
            o_busy      <= 1'b0;
            o_paddr     <= '0;
            o_pwrite    <= 1'b0;
            o_psel      <= 1'b0;
            o_penable   <= 1'b0;
            o_pwdata    <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            o_req_ack   <= ack_d;
            o_req_rdata <= rdata_d;
            o_req_err   <= err_d;
            o_grant     <= grant_d;
            o_busy      <= busy_d;
            o_paddr     <= paddr_d;
            o_pwrite    <= pwrite_d;
            o_psel      <= psel_d;
            o_penable   <= penable_d;
            o_pwdata    <= pwdata_d;
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
module tb_apb_master_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic [N-1:0]    i_req = '0;
    logic [N-1:0]    i_req_write = '0;
    logic [N*AW-1:0] i_req_addr = '0;
    logic [N*DW-1:0] i_req_wdata = '0;
    logic [N-1:0]    o_req_ack;
    logic [DW-1:0]   o_req_rdata;
    logic            o_req_err;
    logic [N-1:0]    o_grant;
    logic            o_busy;
    logic [AW-1:0]   o_paddr;
    logic            o_pwrite;
    logic            o_psel;
    logic            o_penable;
    logic [DW-1:0]   o_pwdata;
    logic [DW-1:0]   i_prdata = '0;
    logic            i_pready = 1'b0;
    logic            i_pslverr = 1'b0;

    apb_master_arbiter #(
        .N_REQ(N),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req(i_req), .i_req_write(i_req_write),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_req_ack(o_req_ack), .o_req_rdata(o_req_rdata), .o_req_err(o_req_err),
        .o_grant(o_grant), .o_busy(o_busy),
        .o_paddr(o_paddr), .o_pwrite(o_pwrite), .o_psel(o_psel),
        .o_penable(o_penable), .o_pwdata(o_pwdata),
        .i_prdata(i_prdata), .i_pready(i_pready), .i_pslverr(i_pslverr)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected completions, filled by the stimulus side.
    typedef struct packed {
        logic [N-1:0]  ack;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;
    exp_t exp_q[$];

    // Slave model: PREADY in the (ws+1)-th ACCESS cycle; ws >= 99 never answers.
    int          slv_ws = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err = 1'b0;
    int          acc = 0;

    always @(negedge i_clk) begin
        if (o_psel && o_penable) acc = acc + 1;
        else acc = 0;
        i_pready  = o_psel && o_penable && (slv_ws < 99) && (acc == slv_ws + 1);
        i_prdata  = slv_rdata;
        i_pslverr = slv_err;
    end

    // Monitor: pops one expected entry per ack pulse.
    always @(negedge i_clk) begin
        exp_t e;
        if (!i_rst && o_busy) check("grant_onehot", 64'($onehot(o_grant)), 64'd1);
        if (o_req_ack != '0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_ack: got %0h expected none", o_req_ack);
            end else begin
                e = exp_q.pop_front();
                check("ack_vec", 64'(o_req_ack), 64'(e.ack));
                check("ack_rdata", 64'(o_req_rdata), 64'(e.rdata));
                check("ack_err", 64'(o_req_err), 64'(e.err));
            end
        end
    end

    task automatic push_exp(input int k, input logic [31:0] rd, input logic err);
        exp_t e;
        e.ack   = N'(1) << k;
        e.rdata = rd;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    // Single transfer from an idle bus; checks phase timing and field stability.
    task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int ws, input logic [31:0] rd,
                        input logic serr, input logic [31:0] exp_rd, input logic exp_err,
                        input int exp_pen);
        int lat;
        int pen;
        bit got;
        lat = (ws < 16) ? ws + 3 : 18;
        pen = 0;
        got = 0;
        slv_ws = ws; slv_rdata = rd; slv_err = serr;
        push_exp(k, exp_rd, exp_err);
        i_req_write[k] = wr;
        i_req_addr[k*AW +: AW] = addr;
        i_req_wdata[k*DW +: DW] = wdata;
        i_req[k] = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge i_clk);
            if (cyc == 1) begin
                check("setup_ctrl", 64'({o_psel, o_penable, o_busy, o_grant}),
                      64'({1'b1, 1'b0, 1'b1, N'(1) << k}));
                i_req_addr[k*AW +: AW] = ~addr;  // must be ignored after grant
                i_req_wdata[k*DW +: DW] = ~wdata;
            end
            if (o_psel) begin
                check("paddr_hold", 64'(o_paddr), 64'(addr));
                check("pwdata_hold", 64'({o_pwrite, o_pwdata}), 64'({wr, wdata}));
            end
            if (o_penable) pen++;
            if (o_req_ack[k]) begin
                got = 1;
                check("ack_latency", 64'(cyc), 64'(lat));
                check("ack_bus_idle", 64'({o_psel, o_penable, o_busy, o_grant}), 64'd0);
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL ack_timeout: got no ack expected ack from req%0d", k);
        end
        check("penable_cycles", 64'(pen), 64'(exp_pen));
        i_req[k] = 1'b0;
    endtask

    // Both requesters held; grants must alternate starting at requester 0.
    task automatic both_held(input int n);
        int acks;
        int nxt;
        acks = 0;
        nxt = 0;
        slv_ws = 0; slv_rdata = 32'hA5A5_0F0F; slv_err = 1'b0;
        i_req_write = 2'b01;  // req0 writes, req1 reads
        i_req_addr = {32'h0000_0200, 32'h0000_0100};
        i_req_wdata = {32'h0, 32'h1111_2222};
        for (int j = 0; j < n; j++) push_exp(j % 2, (j % 2 == 1) ? 32'hA5A5_0F0F : 32'h0, 1'b0);
        i_req = 2'b11;
        for (int cyc = 0; cyc < 60 && acks < n; cyc++) begin
            @(negedge i_clk);
            if (o_psel && !o_penable) begin
                check("rr_grant", 64'(o_grant), 64'(N'(1) << nxt));
                nxt ^= 1;
            end
            if (o_req_ack != '0) acks++;
        end
        i_req = 2'b00;
        check("rr_ack_count", 64'(acks), 64'(n));
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        i_req = '0;
        #1;
        check("rst_ctrl", 64'({o_req_ack, o_req_err, o_grant, o_busy, o_pwrite, o_psel, o_penable}), 64'd0);
        check("rst_data", 64'({o_paddr, o_pwdata}), 64'd0);
        check("rst_rdata", 64'(o_req_rdata), 64'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    initial begin
        bit seen;
        do_reset();

        // write, zero-wait slave
        xfer(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h5555_5555, 1'b0, 32'h0, 1'b0, 1);
        @(negedge i_clk);
        // read with 3 wait states
        xfer(1, 1'b0, 32'h0000_1004, 32'h0, 3, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0, 4);
        @(negedge i_clk);

        // round-robin from reset
        do_reset();
        both_held(4);
        @(negedge i_clk);

        // hung slave -> timeout, then a normal transfer
        xfer(0, 1'b0, 32'h0000_0040, 32'h0, 99, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1, 16);
        @(negedge i_clk);
        xfer(1, 1'b1, 32'h0000_0044, 32'h0BAD_F00D, 0, 32'h0, 1'b0, 32'h0, 1'b0, 1);
        @(negedge i_clk);
        // slave error on a write
        xfer(0, 1'b1, 32'h0000_0080, 32'h0000_00FF, 1, 32'h0, 1'b1, 32'h0, 1'b1, 2);
        @(negedge i_clk);
        // PREADY on the exact timeout cycle wins
        xfer(1, 1'b0, 32'h0000_0084, 32'h0, 15, 32'hCAFE_F00D, 1'b0, 32'hCAFE_F00D, 1'b0, 16);
        @(negedge i_clk);

        // reset during ACCESS: no ack, everything back to zero
        slv_ws = 99;
        i_req_write[0] = 1'b0;
        i_req_addr[0 +: AW] = 32'h0000_0300;
        i_req[0] = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 10 && !seen; cyc++) begin
            @(negedge i_clk);
            if (o_penable) seen = 1;
        end
        check("reach_access", 64'(seen), 64'd1);
        @(negedge i_clk);
        do_reset();
        xfer(1, 1'b0, 32'h0000_2000, 32'h0, 0, 32'h0BAD_CAFE, 1'b0, 32'h0BAD_CAFE, 1'b0, 1);
        @(negedge i_clk);

        // pointer reverts on reset: req0 first when both request
        do_reset();
        both_held(2);
        repeat (3) @(negedge i_clk);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
